// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the RAM arbiter slice: requester indices, the
// ownership/tag encoding and a helper that turns an owner into a one-hot
// requester vector.
// No ports (package).
package ram_arbiter_pkg;

    localparam int NUM_REQ    = 3;
    localparam int REQ_LOADER = 0;
    localparam int REQ_CPU    = 1;
    localparam int REQ_BLIT   = 2;

    // Owner encoding doubles as the requester tag carried down the read
    // pipeline; OWNER_NONE marks the unlocked (idle) ownership state.
    typedef enum logic [1:0] {
        OWNER_LOADER = 2'd0,
        OWNER_CPU    = 2'd1,
        OWNER_BLIT   = 2'd2,
        OWNER_NONE   = 2'd3
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e tag;
    } tag_t;

    function automatic logic [NUM_REQ-1:0] ownerOneHot(input owner_e k);
        logic [NUM_REQ-1:0] v;
        v = '0;
        case (k)
            OWNER_LOADER: v = 3'b001;
            OWNER_CPU:    v = 3'b010;
            OWNER_BLIT:   v = 3'b100;
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles the three requester ports (loader, CPU, blitter) and the RAM
// primitive port of the arbiter.
//   req/lock/wr   per-requester request, burst lock and write select
//   addr/wdata    packed per-requester address and write data
//   gnt/rvalid    per-requester grant and read-data-valid
//   rdata         shared read data
//   ram_*         registered RAM controls and RAM read data
// slave  : arbiter view.  master : requester + RAM side view.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        wr;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      ram_en;
    logic                      ram_wr;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_in;
    logic [DATA_W-1:0]         ram_out;

    modport slave (
        input  req, lock, wr, addr, wdata, ram_out,
        output gnt, rvalid, rdata, ram_en, ram_wr, ram_addr, ram_in
    );

    modport master (
        output req, lock, wr, addr, wdata, ram_out,
        input  gnt, rvalid, rdata, ram_en, ram_wr, ram_addr, ram_in
    );

endinterface

// File: rtl/ram_arbiter_tagpipe.sv
// ram_arbiter_tagpipe
// Carries {valid, requester} for each issued read alongside the RAM access so
// that the returning read data can be routed to the requester that asked.
//   i_clk, i_res  clock and synchronous active-high reset (flushes the pipe)
//   i_valid       a read was granted this cycle
//   i_tag         requester that was granted
//   o_rvalid      one-hot read-valid, DEPTH cycles after the grant edge
module ram_arbiter_tagpipe
    import ram_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_res,
    input  logic               i_valid,
    input  owner_e             i_tag,
    output logic [NUM_REQ-1:0] o_rvalid
);

    tag_t r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= '{valid: i_valid, tag: i_tag};
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    always_comb begin
        o_rvalid = '0;
        if (r_pipe[DEPTH-1].valid) o_rvalid = ownerOneHot(r_pipe[DEPTH-1].tag);
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port RAM between the ROM loader, CPU and blitter.
// The loader has fixed priority, CPU and blitter alternate round-robin, and a
// requester holding lock keeps ownership for a capped burst. At most one
// access is issued per cycle; RAM controls are registered and read data is
// routed back through a tag pipeline.
//   clk, res  clock and synchronous active-high reset
//   bus       ram_arbiter_if slave: requester handshake and RAM port
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_BURST   = 16
) (
    input logic          clk,
    input logic          res,
    ram_arbiter_if.slave bus
);

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    owner_e              r_owner;
    owner_e              w_ownerNext;
    logic [7:0]          r_burstCnt;
    logic [7:0]          w_burstNext;
    owner_e              r_rrPtr;
    owner_e              w_rrNext;
    logic [3:0]          w_reqExt;
    logic                w_winValid;
    owner_e              w_winIdx;
    logic                w_selLock;
    logic                w_selWr;
    logic [ADDR_W-1:0]   w_selAddr;
    logic [DATA_W-1:0]   w_selData;
    logic                r_ramEn;
    logic                r_ramWr;
    logic [ADDR_W-1:0]   r_ramAddr;
    logic [DATA_W-1:0]   r_ramIn;
    logic [NUM_REQ-1:0]  w_rvalid;

    // Winner selection. The request vector is padded so the idle owner code
    // indexes a constant zero. An owner at the burst cap drops to the normal
    // loader/round-robin rules for one arbitration.
    always_comb begin
        w_reqExt   = {1'b0, bus.req};
        w_winValid = 1'b0;
        w_winIdx   = OWNER_NONE;
        if (!res) begin
            if (r_owner != OWNER_NONE && w_reqExt[r_owner] && r_burstCnt < MAX_BURST_C) begin
                w_winValid = 1'b1;
                w_winIdx   = r_owner;
            end else if (bus.req[REQ_LOADER]) begin
                w_winValid = 1'b1;
                w_winIdx   = OWNER_LOADER;
            end else if (bus.req[REQ_CPU] && bus.req[REQ_BLIT]) begin
                w_winValid = 1'b1;
                w_winIdx   = r_rrPtr;
            end else if (bus.req[REQ_CPU]) begin
                w_winValid = 1'b1;
                w_winIdx   = OWNER_CPU;
            end else if (bus.req[REQ_BLIT]) begin
                w_winValid = 1'b1;
                w_winIdx   = OWNER_BLIT;
            end
        end
    end

    // Mux the winning requester's access fields.
    always_comb begin
        w_selLock = 1'b0;
        w_selWr   = 1'b0;
        w_selAddr = '0;
        w_selData = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winValid && int'(w_winIdx) == k) begin
                w_selLock = bus.lock[k];
                w_selWr   = bus.wr[k];
                w_selAddr = bus.addr[k*ADDR_W +: ADDR_W];
                w_selData = bus.wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Ownership / burst / round-robin next state. A cycle without any grant
    // means nobody is requesting, so a lock owner has let go.
    always_comb begin
        w_ownerNext = r_owner;
        w_burstNext = r_burstCnt;
        w_rrNext    = r_rrPtr;
        if (w_winValid) begin
            if (w_selLock) begin
                w_ownerNext = w_winIdx;
                w_burstNext = (r_owner == w_winIdx && r_burstCnt < MAX_BURST_C) ?
                              r_burstCnt + 8'd1 : 8'd1;
            end else begin
                w_ownerNext = OWNER_NONE;
                w_burstNext = 8'd0;
            end
            if (w_winIdx != OWNER_LOADER)
                w_rrNext = (r_rrPtr == OWNER_CPU) ? OWNER_BLIT : OWNER_CPU;
        end else begin
            w_ownerNext = OWNER_NONE;
            w_burstNext = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_owner    <= OWNER_NONE;
            r_burstCnt <= 8'd0;
            r_rrPtr    <= OWNER_CPU;
        end else begin
            r_owner    <= w_ownerNext;
            r_burstCnt <= w_burstNext;
            r_rrPtr    <= w_rrNext;
        end
    end

    // RAM port registers; address and data hold when no access is issued.
    always_ff @(posedge clk) begin
        if (res) begin
            r_ramEn   <= 1'b0;
            r_ramWr   <= 1'b0;
            r_ramAddr <= '0;
            r_ramIn   <= '0;
        end else begin
            r_ramEn <= w_winValid;
            r_ramWr <= w_winValid & w_selWr;
            if (w_winValid) begin
                r_ramAddr <= w_selAddr;
                r_ramIn   <= w_selData;
            end
        end
    end

    ram_arbiter_tagpipe #(
        .DEPTH (RAM_LATENCY + 1)
    ) u_tagpipe (
        .i_clk    (clk),
        .i_res    (res),
        .i_valid  (w_winValid & ~w_selWr),
        .i_tag    (w_winIdx),
        .o_rvalid (w_rvalid)
    );

    assign bus.gnt      = w_winValid ? ownerOneHot(w_winIdx) : '0;
    assign bus.rvalid   = w_rvalid;
    assign bus.rdata    = bus.ram_out;
    assign bus.ram_en   = r_ramEn;
    assign bus.ram_wr   = r_ramWr;
    assign bus.ram_addr = r_ramAddr;
    assign bus.ram_in   = r_ramIn;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with RAM_LATENCY=1, MAX_BURST=16 and a
// one-cycle synchronous RAM whose initial contents are addr[7:0]^8'h3C.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ram_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    ram_arbiter #(
        .ADDR_W      (12),
        .DATA_W      (8),
        .RAM_LATENCY (1),
        .MAX_BURST   (16)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model, preloaded on the first clock edge.
    logic [7:0] mem [4096];
    logic       memLoaded = 1'b0;
    logic [7:0] ramOut = 8'h00;

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h3C;
            memLoaded <= 1'b1;
        end else if (bus.ram_en) begin
            if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_in;
            else            ramOut <= mem[bus.ram_addr];
        end
    end

    assign bus.ram_out = ramOut;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic r, input logic l, input logic w,
                                 input logic [11:0] a, input logic [7:0] d);
        bus.req[k]          = r;
        bus.lock[k]         = l;
        bus.wr[k]           = w;
        bus.addr[k*12 +: 12] = a;
        bus.wdata[k*8 +: 8]  = d;
    endtask

    task automatic clearReqs();
        bus.req   = '0;
        bus.lock  = '0;
        bus.wr    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic resetDut();
        res = 1'b1;
        clearReqs();
        tick();
        tick();
        res = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        clearReqs();
        tick();
        tick();
        bus.req = 3'b111;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_gnt: got %b expected 000", bus.gnt);
        end
        checks++;
        if ({bus.ram_en, bus.ram_wr, bus.ram_addr, bus.ram_in, bus.rvalid} !== 25'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got en=%b wr=%b addr=%h in=%h rv=%b expected all zero",
                     bus.ram_en, bus.ram_wr, bus.ram_addr, bus.ram_in, bus.rvalid);
        end
        tick();
        res = 1'b0;
        clearReqs();
    endtask

    task automatic test_cpu_reads();
        logic [7:0] expBytes [3] = '{8'hBC, 8'hBD, 8'hBE};
        logic [2:0] expG;
        logic [2:0] expRv;
        resetDut();
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c < 3) applyStimulus(1, 1'b1, 1'b0, 1'b0, 12'(12'h180 + c), 8'h00);
            else       applyStimulus(1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
            expG  = (c < 3) ? 3'b010 : 3'b000;
            expRv = (c >= 2 && c <= 4) ? 3'b010 : 3'b000;
            @(negedge clk);
            checks++;
            if (bus.gnt !== expG) begin
                errors++;
                $display("[TB] FAIL cpu_reads_gnt c=%0d: got %b expected %b", c, bus.gnt, expG);
            end
            checks++;
            if (bus.rvalid !== expRv) begin
                errors++;
                $display("[TB] FAIL cpu_reads_rvalid c=%0d: got %b expected %b", c, bus.rvalid, expRv);
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (bus.ram_en !== 1'b1 || bus.ram_wr !== 1'b0 || bus.ram_addr !== 12'(12'h180 + c - 1)) begin
                    errors++;
                    $display("[TB] FAIL cpu_reads_ram c=%0d: got en=%b wr=%b addr=%h expected en=1 wr=0 addr=%h",
                             c, bus.ram_en, bus.ram_wr, bus.ram_addr, 12'(12'h180 + c - 1));
                end
            end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (bus.rdata !== expBytes[c-2]) begin
                    errors++;
                    $display("[TB] FAIL cpu_reads_rdata c=%0d: got %h expected %h", c, bus.rdata, expBytes[c-2]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] expG;
        logic [2:0] expRv;
        logic [7:0] expD;
        resetDut();
        for (int c = 0; c < 6; c++) begin
            tick();
            applyStimulus(1, c < 4, 1'b0, 1'b0, 12'h010, 8'h00);
            applyStimulus(2, c < 4, 1'b0, 1'b0, 12'h020, 8'h00);
            expG  = (c >= 4) ? 3'b000 : ((c % 2 == 0) ? 3'b010 : 3'b100);
            expRv = (c < 2) ? 3'b000 : ((c % 2 == 0) ? 3'b010 : 3'b100);
            expD  = (c % 2 == 0) ? 8'h2C : 8'h1C;
            @(negedge clk);
            checks++;
            if (bus.gnt !== expG) begin
                errors++;
                $display("[TB] FAIL round_robin_gnt c=%0d: got %b expected %b", c, bus.gnt, expG);
            end
            checks++;
            if (bus.rvalid !== expRv) begin
                errors++;
                $display("[TB] FAIL round_robin_rvalid c=%0d: got %b expected %b", c, bus.rvalid, expRv);
            end
            if (c >= 2) begin
                checks++;
                if (bus.rdata !== expD) begin
                    errors++;
                    $display("[TB] FAIL round_robin_rdata c=%0d: got %h expected %h", c, bus.rdata, expD);
                end
            end
        end
    endtask

    task automatic test_burst_cap();
        logic [2:0] hist [24];
        logic [2:0] expG;
        logic [2:0] expRv;
        resetDut();
        for (int c = 0; c < 24; c++) begin
            tick();
            applyStimulus(2, c <= 20, 1'b1, 1'b0, 12'h300, 8'h00);
            applyStimulus(1, c >= 1 && c <= 21, 1'b0, 1'b0, 12'h040, 8'h00);
            if (c <= 15 || (c >= 17 && c <= 20)) expG = 3'b100;
            else if (c == 16 || c == 21)         expG = 3'b010;
            else                                 expG = 3'b000;
            expRv   = (c >= 2) ? hist[c-2] : 3'b000;
            hist[c] = expG;
            @(negedge clk);
            checks++;
            if (bus.gnt !== expG) begin
                errors++;
                $display("[TB] FAIL burst_cap_gnt c=%0d: got %b expected %b", c, bus.gnt, expG);
            end
            checks++;
            if (bus.rvalid !== expRv) begin
                errors++;
                $display("[TB] FAIL burst_cap_rvalid c=%0d: got %b expected %b", c, bus.rvalid, expRv);
            end
        end
    endtask

    task automatic test_loader_preempt();
        logic [2:0] expG [4] = '{3'b010, 3'b010, 3'b001, 3'b010};
        resetDut();
        for (int c = 0; c < 4; c++) begin
            tick();
            applyStimulus(1, 1'b1, 1'b0, 1'b0, 12'h060, 8'h00);
            applyStimulus(0, c == 2, 1'b0, 1'b0, 12'h000, 8'h00);
            @(negedge clk);
            checks++;
            if (bus.gnt !== expG[c]) begin
                errors++;
                $display("[TB] FAIL loader_preempt_gnt c=%0d: got %b expected %b", c, bus.gnt, expG[c]);
            end
        end
    endtask

    task automatic test_loader_locked();
        logic [2:0] expG [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010};
        resetDut();
        for (int c = 0; c < 6; c++) begin
            tick();
            applyStimulus(1, 1'b1, c <= 2, 1'b0, 12'h070, 8'h00);
            applyStimulus(0, c >= 1 && c <= 4, 1'b0, 1'b0, 12'h001, 8'h00);
            @(negedge clk);
            checks++;
            if (bus.gnt !== expG[c]) begin
                errors++;
                $display("[TB] FAIL loader_locked_gnt c=%0d: got %b expected %b", c, bus.gnt, expG[c]);
            end
        end
    endtask

    task automatic test_loader_cap();
        logic [2:0] expG;
        resetDut();
        for (int c = 0; c < 18; c++) begin
            tick();
            applyStimulus(1, 1'b1, 1'b1, 1'b0, 12'h080, 8'h00);
            applyStimulus(0, c >= 1 && c <= 16, 1'b0, 1'b0, 12'h002, 8'h00);
            expG = (c == 16) ? 3'b001 : 3'b010;
            @(negedge clk);
            checks++;
            if (bus.gnt !== expG) begin
                errors++;
                $display("[TB] FAIL loader_cap_gnt c=%0d: got %b expected %b", c, bus.gnt, expG);
            end
        end
    endtask

    task automatic test_back_to_back();
        resetDut();
        tick();
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 12'h200, 8'hA5);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b010) begin
            errors++;
            $display("[TB] FAIL b2b_write_gnt: got %b expected 010", bus.gnt);
        end
        tick();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 12'h200, 8'h00);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b100) begin
            errors++;
            $display("[TB] FAIL b2b_read_gnt: got %b expected 100", bus.gnt);
        end
        checks++;
        if ({bus.ram_en, bus.ram_wr, bus.ram_addr, bus.ram_in} !== {1'b1, 1'b1, 12'h200, 8'hA5}) begin
            errors++;
            $display("[TB] FAIL b2b_write_strobe: got en=%b wr=%b addr=%h in=%h expected en=1 wr=1 addr=200 in=a5",
                     bus.ram_en, bus.ram_wr, bus.ram_addr, bus.ram_in);
        end
        tick();
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 3'b000 || bus.ram_en !== 1'b1 || bus.ram_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_after_write: got rv=%b en=%b wr=%b expected rv=000 en=1 wr=0",
                     bus.rvalid, bus.ram_en, bus.ram_wr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 3'b100 || bus.rdata !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL b2b_read_data: got rv=%b data=%h expected rv=100 data=a5", bus.rvalid, bus.rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 3'b000) begin
            errors++;
            $display("[TB] FAIL b2b_rvalid_single: got %b expected 000", bus.rvalid);
        end
    endtask

    task automatic test_reset_inflight();
        resetDut();
        tick();
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 12'h050, 8'h00);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b010) begin
            errors++;
            $display("[TB] FAIL inflight_gnt: got %b expected 010", bus.gnt);
        end
        tick();
        res = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b000) begin
            errors++;
            $display("[TB] FAIL inflight_gnt_in_reset: got %b expected 000", bus.gnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.ram_en, bus.ram_wr, bus.ram_addr, bus.ram_in, bus.rvalid, bus.gnt} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL inflight_reset_state: got en=%b wr=%b addr=%h in=%h rv=%b gnt=%b expected all zero",
                     bus.ram_en, bus.ram_wr, bus.ram_addr, bus.ram_in, bus.rvalid, bus.gnt);
        end
        tick();
        res = 1'b0;
        clearReqs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.rvalid !== 3'b000) begin
                errors++;
                $display("[TB] FAIL inflight_no_rvalid c=%0d: got %b expected 000", c, bus.rvalid);
            end
            tick();
        end
    endtask

    initial begin
        clearReqs();
        test_reset();
        test_cpu_reads();
        test_round_robin();
        test_burst_cap();
        test_loader_preempt();
        test_loader_locked();
        test_loader_cap();
        test_back_to_back();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 4 KiB program/data RAM between three requesters: ROM loader, CPU and blitter.
- Issues at most one RAM access per cycle.
- Arbitration policy: loader has fixed priority; CPU and blitter share access round-robin.
- Supports locked bursts (CPU F?55/F?65 loops, blitter sprite-row fetch) with a starvation cap.
- Sits between the cpu/blitter/loader ports and the RAM primitive; routes read data back to the issuing requester.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 8, RAM data width
RAM_LATENCY, 1, cycles from RAM sampling ram_addr to valid ram_out (1..3)
MAX_BURST, 16, maximum consecutive locked grants to one owner (2..255)

Ports:
clk  in  1  system clock
res  in  1  synchronous active-high reset
req  in  3  access request per requester: [0] loader, [1] CPU, [2] blitter
lock  in  3  hold ownership for next access while req stays high
wr  in  3  1 = write, 0 = read, per requester
addr  in  3*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W]
wdata  in  3*DATA_W  packed write data
gnt  out  3  combinational accept; access taken at the end of this cycle
rvalid  out  3  read data valid for requester k
rdata  out  DATA_W  read data, shared by all requesters; qualified by rvalid
ram_en  out  1  RAM enable (registered)
ram_wr  out  1  RAM write strobe (registered)
ram_addr  out  ADDR_W  RAM address (registered)
ram_in  out  DATA_W  RAM write data (registered)
ram_out  in  DATA_W  RAM read data

Behaviour:
- Reset values:
  - ram_en=0, ram_wr=0, ram_addr=0, ram_in=0, rvalid=0.
  - owner=NONE, burst_cnt=0, rr_ptr=CPU.
  - The read tag pipeline is flushed, so no rvalid appears after reset for accesses issued before it.
  - While res is high, gnt=0.
- Handshake:
  - A requester holds req/wr/addr/wdata stable until it sees gnt high.
  - An access transfers at the clock edge where req&gnt are both high.
  - The requester may present its next access in the following cycle.
  - This gives back-to-back throughput of 1 access/cycle.
- gnt is one-hot or zero. It is a combinational function of req, lock state, owner, burst_cnt and rr_ptr. It never depends on ram_out.
- Winner selection, in order:
  1. If owner!=NONE, req[owner]=1 and burst_cnt<MAX_BURST, the owner wins.
  2. Else if req[0], the loader wins.
  3. Else CPU vs blitter: a single requester wins; if both request, the one selected by rr_ptr wins.
- Ownership states:
  - IDLE (owner=NONE) and LOCKED(k).
  - On a grant with lock[k]=1: enter/stay LOCKED(k); burst_cnt <= (owner==k ? burst_cnt+1 : 1).
  - On a grant with lock[k]=0: go to IDLE; burst_cnt <= 0.
  - LOCKED(k) with req[k]=0 in any cycle: go to IDLE. Another requester may win in that same cycle.
  - burst_cnt==MAX_BURST: the owner loses step-1 priority for one arbitration. It may still win via steps 2–3. If it wins, burst_cnt restarts at 1.
- rr_ptr toggles to the other of CPU/blitter after every grant to CPU or blitter. Loader grants leave it unchanged.
- RAM outputs:
  - On a grant in cycle t, ram_en=1, ram_wr=wr[k], ram_addr, ram_in are visible in cycle t+1.
  - With no grant, ram_en=0 and ram_wr=0 in t+1; addr/data hold their previous values.
- Read return:
  - A read granted in cycle t produces rvalid[k]=1 for exactly one cycle, t+1+RAM_LATENCY, with rdata=ram_out.
  - Writes produce no rvalid.
  - Up to 1+RAM_LATENCY reads can be in flight; a tag shift register carries {valid, requester}.
- Data widths: addresses pass through unmodified. There is no wrap or increment in the arbiter; requesters own address sequencing.
- Simultaneous events:
  - A locked owner releasing lock while a higher-priority requester asks: the owner still wins the current access. Ownership clears after that grant.
  - Reset asserted mid-burst: the next cycle is the reset state and in-flight reads are discarded.

Decomposition:
- Header ram_arb.vh holds:
  - REQ_LOADER=0, REQ_CPU=1, REQ_BLIT=2
  - OWNER_NONE=2'd3
  - requester count 3
- One sub-module, ram_arb_tagpipe: RAM_LATENCY+1 deep shift register of {valid, 2-bit tag} producing rvalid one-hot.
- Priority/round-robin logic stays in the top module.

Test Plan:
1. CPU-only reads, req[1] held with addrs 0x180,0x181,0x182 back-to-back, RAM_LATENCY=1 -> gnt[1] high 3 consecutive cycles; rvalid[1] cycles t+2..t+4 with bytes at those addrs.
2. CPU and blitter both request unlocked reads continuously -> grants alternate CPU, BLIT, CPU, …, starting with CPU after reset; each rvalid routed to the correct requester.
3. Blitter locked burst of 20 reads, CPU requesting throughout, MAX_BURST=16 -> blitter gets 16 consecutive grants, CPU gets 1, blitter resumes at burst_cnt=1.
4. Loader request arrives during a CPU unlocked stream -> loader wins the next cycle; during a locked CPU burst, loader waits until lock drops or the cap is hit.
5. CPU write 0xA5 to 0x200, then blitter read 0x200 in the next cycle -> ram_wr pulse with ram_in=0xA5; blitter rvalid with rdata=0xA5.
6. res asserted one cycle after a read grant -> no rvalid ever appears for that read; all outputs at reset values in the next cycle.
